// File: rtl/alu_step_top.sv
// alu_step_top: single-step ALU driven by a debounced pushbutton and DIP switches.
//
// Each accepted press runs one operation through a four-state sequencer.
// The operands and a one-hot opcode are latched from the switches. The result
// and its flags are registered. Valid results update the accumulator, a small
// result history and a 2-bit operation counter.
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   rst       synchronous, active-high reset
//   btn_step  raw asynchronous pushbutton; a debounced rising press requests one step
//   dip_sw    [7:0] op1, [15:8] op2, [27:16] one-hot opcode, [28] acc_mode,
//             [29] view, [31:30] history index
//   leds      registered display: [7:0] value, [8] Z, [9] C, [10] V, [11] err,
//             [12] busy, [13] captured acc_mode, [15:14] op count
//
// Sequencer states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for a step pulse; pulses in other states are dropped
//   S_CAPTURE | latch src1 (accumulator or op1), src2 and opcode
//   S_EXEC    | evaluate the ALU and register the result and flags
//   S_COMMIT  | valid op: update accumulator, history, pointer and count

module alu_step_top #(
  parameter int DATA_WIDTH      = 8,
  parameter int HIST_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic [31:0] dip_sw,
  output logic [15:0] leds
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int HPW = $clog2(HIST_DEPTH);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DBW-1:0] DB_TC = DBW'(DEBOUNCE_CYCLES - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_EXEC,
    S_COMMIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Switch fields
  // ---------------------------------------------------------------------------
  word_t          op1;
  word_t          op2;
  logic [11:0]    opcode_sw;
  logic           acc_mode_sw;
  logic           view;
  logic [HPW-1:0] hist_idx;

  assign op1         = dip_sw[DATA_WIDTH-1:0];
  assign op2         = dip_sw[8 +: DATA_WIDTH];
  assign opcode_sw   = dip_sw[27:16];
  assign acc_mode_sw = dip_sw[28];
  assign view        = dip_sw[29];
  assign hist_idx    = dip_sw[30 +: HPW];

  // ---------------------------------------------------------------------------
  // Button synchroniser, debouncer and step pulse
  // ---------------------------------------------------------------------------
  logic           sync1;
  logic           sync2;
  logic           db_level;
  logic           db_prev;
  logic [DBW-1:0] db_cnt;
  logic           armed;
  logic [DBW-1:0] arm_cnt;
  logic           step;

  // db_cnt counts consecutive samples that disagree with the accepted level.
  // The level flips on the DEBOUNCE_CYCLES-th disagreeing sample.
  // armed stays low after reset until the synchronised input has been low for
  // DEBOUNCE_CYCLES consecutive samples. A button held through reset therefore
  // needs a real release before its next press can produce a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
      armed    <= 1'b0;
      arm_cnt  <= DB_TC;
    end else begin
      sync1   <= btn_step;
      sync2   <= sync1;
      db_prev <= db_level;

      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end

      if (!armed) begin
        if (sync2) begin
          arm_cnt <= DB_TC;
        end else if (arm_cnt == '0) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt - DBW'(1);
        end
      end
    end
  end

  assign step = armed & db_level & ~db_prev;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:    if (step) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_EXEC;
      S_EXEC:    state_next = S_COMMIT;
      S_COMMIT:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  word_t          src1_q, src1_d;
  word_t          src2_q, src2_d;
  logic [11:0]    opc_q, opc_d;
  logic           accm_q, accm_d;
  word_t          res_q, res_d;
  logic           z_q, z_d;
  logic           c_q, c_d;
  logic           v_q, v_d;
  logic           err_q, err_d;
  word_t          acc_q, acc_d;
  logic [HPW-1:0] wptr_q, wptr_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           hist_we;
  word_t          hist_q [HIST_DEPTH];

  // ALU
  word_t             alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              opc_valid;
  logic [DATA_WIDTH:0] sum_ext;
  word_t             diff;
  logic [SHW-1:0]    shamt;

  assign sum_ext   = {1'b0, src1_q} + {1'b0, src2_q};
  assign diff      = src1_q - src2_q;
  assign shamt     = src2_q[SHW-1:0];
  assign opc_valid = (opc_q != 12'd0) && ((opc_q & (opc_q - 12'd1)) == 12'd0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (opc_valid) begin
      if (opc_q[0]) begin
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = (src1_q[DATA_WIDTH-1] == src2_q[DATA_WIDTH-1]) &&
                  (alu_res[DATA_WIDTH-1] != src1_q[DATA_WIDTH-1]);
      end else if (opc_q[1]) begin
        alu_res = diff;
        alu_c   = src1_q < src2_q;
        alu_v   = (src1_q[DATA_WIDTH-1] != src2_q[DATA_WIDTH-1]) &&
                  (alu_res[DATA_WIDTH-1] != src1_q[DATA_WIDTH-1]);
      end else if (opc_q[2]) begin
        alu_res = word_t'($signed(src1_q) < $signed(src2_q));
      end else if (opc_q[3]) begin
        alu_res = word_t'(src1_q < src2_q);
      end else if (opc_q[4]) begin
        alu_res = src1_q & src2_q;
      end else if (opc_q[5]) begin
        alu_res = ~(src1_q | src2_q);
      end else if (opc_q[6]) begin
        alu_res = src1_q | src2_q;
      end else if (opc_q[7]) begin
        alu_res = src1_q ^ src2_q;
      end else if (opc_q[8]) begin
        alu_res = src1_q << shamt;
      end else if (opc_q[9]) begin
        alu_res = src1_q >> shamt;
      end else if (opc_q[10]) begin
        alu_res = word_t'($signed(src1_q) >>> shamt);
      end else begin
        alu_res = src2_q;
      end
    end
  end

  always_comb begin
    src1_d  = src1_q;
    src2_d  = src2_q;
    opc_d   = opc_q;
    accm_d  = accm_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    acc_d   = acc_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    hist_we = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        src1_d = acc_mode_sw ? acc_q : op1;
        src2_d = op2;
        opc_d  = opcode_sw;
        accm_d = acc_mode_sw;
      end
      S_EXEC: begin
        res_d = alu_res;
        z_d   = opc_valid && (alu_res == '0);
        c_d   = alu_c;
        v_d   = alu_v;
        err_d = !opc_valid;
      end
      S_COMMIT: begin
        if (!err_q) begin
          acc_d   = res_q;
          hist_we = 1'b1;
          wptr_d  = wptr_q + HPW'(1);
          cnt_d   = cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src1_q <= '0;
      src2_q <= '0;
      opc_q  <= '0;
      accm_q <= 1'b0;
      res_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      err_q  <= 1'b0;
      acc_q  <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      src1_q <= src1_d;
      src2_q <= src2_d;
      opc_q  <= opc_d;
      accm_q <= accm_d;
      res_q  <= res_d;
      z_q    <= z_d;
      c_q    <= c_d;
      v_q    <= v_d;
      err_q  <= err_d;
      acc_q  <= acc_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else if (hist_we) begin
      hist_q[wptr_q] <= res_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Display register
  // ---------------------------------------------------------------------------
  // leds is loaded from next-state values. The result therefore appears in the
  // same cycle as the result register, and the history and count appear in the
  // same cycle as the commit they come from. A history read that hits the slot
  // being written this cycle bypasses to the value being written.
  logic [HPW-1:0] rd_addr;
  word_t          hist_rd;
  logic [7:0]     disp8;
  logic [15:0]    leds_d;

  assign rd_addr = wptr_d - HPW'(1) - hist_idx;
  assign hist_rd = (hist_we && (rd_addr == wptr_q)) ? res_q : hist_q[rd_addr];

  always_comb begin
    disp8                 = '0;
    disp8[DATA_WIDTH-1:0] = view ? hist_rd : res_d;
    leds_d = {cnt_d, accm_d, (state_next != S_IDLE), err_d, v_d, c_d, z_d, disp8};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '0;
    end else begin
      leds <= leds_d;
    end
  end

endmodule
